// File: rtl/trig_sincos_pipe_if.sv
// Stream bundle for trig_sincos_pipe: angle/tag in, sin/cos/tag out, each with valid/ready.
`default_nettype none

interface trig_sincos_pipe_if #(
   parameter int ANGLE_W = 9,
   parameter int OUT_W   = 10,
   parameter int TAG_W   = 10
);
   logic               in_valid;
   logic               in_ready;
   logic [ANGLE_W-1:0] in_angle;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_sin;
   logic [OUT_W-1:0]   out_cos;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_angle, in_tag, out_ready,
      input  in_ready, out_valid, out_sin, out_cos, out_tag
   );

   modport slave (
      input  in_valid, in_angle, in_tag, out_ready,
      output in_ready, out_valid, out_sin, out_cos, out_tag
   );
endinterface

`default_nettype wire

// File: rtl/trig_sincos_pipe.sv
// 3-stage sin/cos pipeline: angle reduction, quarter-wave ROM lookup, sign application.
// Optional TRIG_WRAP_FLAG_EN adds out_wrapped and a saturating wrap_count.
`default_nettype none

module trig_sincos_pipe #(
   parameter int ANGLE_W    = 9,
   parameter int SCALE_LOG2 = 5,
   parameter int OUT_W      = 10,
   parameter int TAG_W      = 10
) (
   input  logic                Clk,
   input  logic                Reset_n,
   trig_sincos_pipe_if.slave   bus
`ifdef TRIG_WRAP_FLAG_EN
   ,
   output logic                out_wrapped,
   output logic [15:0]         wrap_count
`endif
);

   localparam int MAG_W = SCALE_LOG2 + 1;
   localparam int N_SUB = ((1 << ANGLE_W) - 1 + 359) / 360;

   // Elaboration-time floor(2^s * sin(k deg)) via a Q30 Taylor series; the small
   // bias keeps the exactly representable points (30 and 90 deg) from flooring low.
   function automatic int quarter_sin(input int k, input int s);
      longint x, x2, term, sum, res;
      x    = (longint'(k) * 64'sd3373259426) / 64'sd180;
      x2   = (x * x) / 64'sd1073741824;
      term = x;
      sum  = x;
      for (int n = 1; n <= 8; n++) begin
         term = -((term * x2) / 64'sd1073741824) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      res = (sum + 64'sd64) >>> (30 - s);
      if (res > (64'sd1 <<< s)) res = 64'sd1 <<< s;
      if (res < 64'sd0)         res = 64'sd0;
      return int'(res);
   endfunction

   logic [MAG_W-1:0] rom [0:90];

   for (genvar k = 0; k <= 90; k++) begin : g_rom
      localparam logic [MAG_W-1:0] ROM_VAL = MAG_W'(quarter_sin(k, SCALE_LOG2));
      assign rom[k] = ROM_VAL;
   end

   logic stall;

   logic               s1_valid;
   logic [8:0]         s1_a;
   logic [1:0]         s1_q;
   logic [TAG_W-1:0]   s1_tag;

   logic               s2_valid;
   logic [MAG_W-1:0]   s2_sin_mag;
   logic [MAG_W-1:0]   s2_cos_mag;
   logic               s2_sin_neg;
   logic               s2_cos_neg;
   logic [TAG_W-1:0]   s2_tag;

   logic               out_valid_r;
   logic [OUT_W-1:0]   out_sin_r;
   logic [OUT_W-1:0]   out_cos_r;
   logic [TAG_W-1:0]   out_tag_r;

   assign stall        = out_valid_r && !bus.out_ready;
   assign bus.in_ready = !stall;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sin   = out_sin_r;
   assign bus.out_cos   = out_cos_r;
   assign bus.out_tag   = out_tag_r;

   logic [ANGLE_W-1:0] red;
   logic [8:0]         red_a;
   logic [1:0]         quad;
   logic               wraps;

   always_comb begin
      red = bus.in_angle;
      for (int i = 0; i < N_SUB; i++) begin
         if (red >= ANGLE_W'(360)) red = red - ANGLE_W'(360);
      end
   end

   assign red_a = 9'(red);
   assign wraps = (bus.in_angle >= ANGLE_W'(360));

   always_comb begin
      if (red_a <= 9'd90)       quad = 2'd0;
      else if (red_a <= 9'd180) quad = 2'd1;
      else if (red_a <= 9'd270) quad = 2'd2;
      else                      quad = 2'd3;
   end

   logic [6:0] sin_idx;
   logic [6:0] cos_idx;
   logic       sin_neg;
   logic       cos_neg;

   always_comb begin
      sin_idx = 7'd0;
      cos_idx = 7'd0;
      sin_neg = 1'b0;
      cos_neg = 1'b0;
      case (s1_q)
         2'd0: begin
            sin_idx = 7'(s1_a);
            cos_idx = 7'(9'd90 - s1_a);
         end
         2'd1: begin
            sin_idx = 7'(9'd180 - s1_a);
            cos_idx = 7'(s1_a - 9'd90);
            cos_neg = 1'b1;
         end
         2'd2: begin
            sin_idx = 7'(s1_a - 9'd180);
            cos_idx = 7'(9'd270 - s1_a);
            sin_neg = 1'b1;
            cos_neg = 1'b1;
         end
         default: begin
            sin_idx = 7'(9'd360 - s1_a);
            cos_idx = 7'(s1_a - 9'd270);
            sin_neg = 1'b1;
         end
      endcase
   end

   logic [OUT_W-1:0] sin_ext;
   logic [OUT_W-1:0] cos_ext;

   assign sin_ext = {{(OUT_W - MAG_W){1'b0}}, s2_sin_mag};
   assign cos_ext = {{(OUT_W - MAG_W){1'b0}}, s2_cos_mag};

   // A stall freezes every stage at once, so bubbles only collapse while flowing.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid    <= 1'b0;
         s1_a        <= '0;
         s1_q        <= '0;
         s1_tag      <= '0;
         s2_valid    <= 1'b0;
         s2_sin_mag  <= '0;
         s2_cos_mag  <= '0;
         s2_sin_neg  <= 1'b0;
         s2_cos_neg  <= 1'b0;
         s2_tag      <= '0;
         out_valid_r <= 1'b0;
         out_sin_r   <= '0;
         out_cos_r   <= '0;
         out_tag_r   <= '0;
      end else if (!stall) begin
         s1_valid    <= bus.in_valid;
         s1_a        <= red_a;
         s1_q        <= quad;
         s1_tag      <= bus.in_tag;
         s2_valid    <= s1_valid;
         s2_sin_mag  <= rom[sin_idx];
         s2_cos_mag  <= rom[cos_idx];
         s2_sin_neg  <= sin_neg;
         s2_cos_neg  <= cos_neg;
         s2_tag      <= s1_tag;
         out_valid_r <= s2_valid;
         out_sin_r   <= s2_sin_neg ? (OUT_W'(0) - sin_ext) : sin_ext;
         out_cos_r   <= s2_cos_neg ? (OUT_W'(0) - cos_ext) : cos_ext;
         out_tag_r   <= s2_tag;
      end
   end

`ifdef TRIG_WRAP_FLAG_EN
   logic s1_wrap;
   logic s2_wrap;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_wrap     <= 1'b0;
         s2_wrap     <= 1'b0;
         out_wrapped <= 1'b0;
      end else if (!stall) begin
         s1_wrap     <= wraps;
         s2_wrap     <= s1_wrap;
         out_wrapped <= s2_wrap;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wrap_count <= 16'd0;
      end else if (bus.in_valid && !stall && wraps && (wrap_count != 16'hFFFF)) begin
         wrap_count <= wrap_count + 16'd1;
      end
   end
`else
   logic unused_wraps;
   assign unused_wraps = wraps;
`endif

endmodule

`default_nettype wire

// File: doc/trig_sincos_pipe.md
Name: trig_sincos_pipe

Overview:
- Pipelined sine/cosine generator for the raycaster's ray-direction datapath.
- Takes an integer-degree angle and returns signed fixed-point sin and cos together, with a pass-through tag (screen column index).
- Replaces per-function full-circle case tables with one quarter-wave ROM, a parametrised amplitude, input angle reduction, and a valid/ready stream interface with backpressure.

Parameters:
- ANGLE_W, 9, angle input width in degrees; 9..12 supported.
- SCALE_LOG2, 5, amplitude is 2^SCALE_LOG2 (32 by default); 4..8 supported.
- OUT_W, 10, signed two's-complement output width; must be >= SCALE_LOG2+2.
- TAG_W, 10, width of the sideband tag carried with each sample.

Ports:
- Clk  in  1  system clock, all state on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_angle  in  ANGLE_W  angle in degrees, unsigned.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_sin  out  OUT_W  signed sin(angle) * 2^SCALE_LOG2.
- out_cos  out  OUT_W  signed cos(angle) * 2^SCALE_LOG2.
- out_tag  out  TAG_W  tag of the output sample.

Behaviour:
- Reset (async assert, sync-released by the system): all stage valids are 0; out_valid=0; out_sin, out_cos and out_tag are 0; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight sample. No output is produced for those samples.
- Transfer occurs on an interface when valid && ready are both 1 at a clock edge.

Pipeline (3 stages, S1..S3):
- Each stage has a valid bit.
- Stall condition: stall = out_valid && !out_ready.
- in_ready = !stall. This is combinational from out_ready, with no registered skid.
- On stall, every stage holds its data and valid bit.
- Without stall, bubbles collapse: each stage loads from the previous one.
- Latency is 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 sample per cycle.
- Samples leave in arrival order. out_sin, out_cos and out_tag are stable while out_valid=1 and out_ready=0.

S1, angle reduction:
- a = in_angle mod 360, computed with repeated conditional subtraction of 360; ceil((2^ANGLE_W-1)/360) subtractors are unrolled.
- Quadrant q and offset: q=0 for a in 0..90, q=1 for 91..180, q=2 for 181..270, q=3 for 271..359.

S2, ROM lookup:
- The quarter-wave ROM holds 91 entries: T[k] = floor(2^SCALE_LOG2 * sin(k deg)) for k=0..90. T[0]=0 and T[90]=2^SCALE_LOG2.
- The ROM is read combinationally with two read ports: sin index and cos index.

S3, sign application, registered to the outputs. Index selection and sign by quadrant:
- q0: sin = T[a], cos = T[90-a].
- q1: sin = T[180-a], cos = -T[a-90].
- q2: sin = -T[a-180], cos = -T[270-a].
- q3: sin = -T[360-a], cos = T[a-270].

Arithmetic rules:
- Negation is two's complement at OUT_W. Negative zero yields 0.
- Outputs are sign-extended; no saturation is needed given the OUT_W constraint.
- Values on the exact axes 0, 90, 180 and 270 give exact ±2^SCALE_LOG2 and 0.

Optional Feature:
- Macro: TRIG_WRAP_FLAG_EN.
- When defined:
  - Adds output port out_wrapped (1 bit). It is 1 when the sample's in_angle was >= 360 and reduced in S1.
  - The flag is pipelined alongside the tag, held under stall, and reset to 0.
  - Adds output port wrap_count (16 bits). It counts accepted input samples with in_angle >= 360, saturates at 16'hFFFF, and resets to 0.
- When undefined: neither port exists and no wrap-flag or counter logic is present.

Test Plan:
- Defaults, out_ready=1, angle 0, tag 5 -> 3 cycles later out_sin=0, out_cos=10'h020, out_tag=5.
- Angles 45, 90, 180, 270 back-to-back -> consecutive cycles with (sin,cos) = (22,22), (32,0), (0,-32=10'h3E0), (-32,0); one output per cycle, in order.
- Angle 400 and angle 40 -> both give sin=20, cos=24. With TRIG_WRAP_FLAG_EN: out_wrapped=1 then 0, and wrap_count=1.
- Stream 0..359 with out_ready toggling pseudo-randomly -> every sample delivered exactly once, in order, and matching the floor-based model. While out_valid && !out_ready: outputs stable and in_ready=0.
- Fill the pipeline with 3 samples and out_ready=0, then assert Reset_n=0 for 1 cycle -> out_valid drops immediately, outputs read 0, no stale sample appears after release.
- SCALE_LOG2=8, OUT_W=12, angle 135 -> sin=181 (floor(256*0.7071)), cos=-181 (12'hF4B).
